// File: rtl/cb_sync_pkg.sv
// ============================================================================
// Module      : cb_sync_pkg
// Description : Shared constants, types and helpers for the cb_sync_filt
//               synchroniser / glitch-filter block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cb_sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

    // Stability counter only needs to reach FILT_CNT-1; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cb_sync_filt_if.sv
// ============================================================================
// Module      : cb_sync_filt_if
// Description : Channel bundle (inputs, filtered levels, edge pulses) for the
//               cb_sync_filt block and its per-channel slices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cb_sync_filt_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] dat_in;
    logic [WIDTH-1:0] dat_out;
    logic [WIDTH-1:0] rise_pls;
    logic [WIDTH-1:0] fall_pls;

    modport master (
        output dat_in,
        input  dat_out,
        input  rise_pls,
        input  fall_pls
    );

    modport slave (
        input  dat_in,
        output dat_out,
        output rise_pls,
        output fall_pls
    );
endinterface

`default_nettype wire

// File: rtl/cb_sync_filt_ch.sv
// ============================================================================
// Module      : cb_sync_filt_ch
// Description : One channel: STAGES-deep synchroniser, stability counter and
//               edge-pulse registers. Pulses built only with CB_SYNC_EDGE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cb_sync_filt_ch
    import cb_sync_pkg::*;
#(
    parameter int   STAGES   = 2,
    parameter int   FILT_CNT = 4,
    parameter logic INT_BIT  = 1'b0
) (
    input  wire logic        clk_sys,
    input  wire logic        rst,
    cb_sync_filt_if.slave    bus
);

    // First STAGES-1 flops; the final stage is r_s (filtered) or r_out (bypass).
    logic [STAGES-2:0] r_sync;
    logic              r_out;
    logic              w_out_nxt;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_sync <= {(STAGES-1){INT_BIT}};
        end else begin
            r_sync[0] <= bus.dat_in[0];
            for (int k = 1; k < STAGES - 1; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    generate
        if (FILT_CNT > 0) begin : g_filt
            localparam int             c_cnt_w   = cnt_width(FILT_CNT);
            localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILT_CNT - 1);

            logic               r_s;
            logic [c_cnt_w-1:0] r_cnt;
            logic [c_cnt_w-1:0] w_cnt_nxt;

            always_ff @(posedge clk_sys) begin
                if (rst) begin
                    r_s   <= INT_BIT;
                    r_cnt <= '0;
                end else begin
                    r_s   <= r_sync[STAGES-2];
                    r_cnt <= w_cnt_nxt;
                end
            end

            // Any return of s to the current output restarts the count.
            always_comb begin
                w_out_nxt = r_out;
                w_cnt_nxt = '0;
                if (r_s != r_out) begin
                    if (r_cnt == c_cnt_max) begin
                        w_out_nxt = r_s;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
            end
        end else begin : g_bypass
            assign w_out_nxt = r_sync[STAGES-2];
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_out <= INT_BIT;
        end else begin
            r_out <= w_out_nxt;
        end
    end

    assign bus.dat_out[0] = r_out;

`ifdef CB_SYNC_EDGE_EN
    edge_e w_edge;
    logic  r_rise;
    logic  r_fall;

    // Pulses are registered from the next-output value so they line up with dat_out.
    always_comb begin
        w_edge = EDGE_NONE;
        if (w_out_nxt && !r_out) begin
            w_edge = EDGE_RISE;
        end else if (!w_out_nxt && r_out) begin
            w_edge = EDGE_FALL;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= (w_edge == EDGE_RISE);
            r_fall <= (w_edge == EDGE_FALL);
        end
    end

    assign bus.rise_pls[0] = r_rise;
    assign bus.fall_pls[0] = r_fall;
`else
    assign bus.rise_pls[0] = 1'b0;
    assign bus.fall_pls[0] = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/cb_sync_filt.sv
// ============================================================================
// Module      : cb_sync_filt
// Description : WIDTH independent synchronise + debounce channels with optional
//               rise/fall pulses (enabled by macro CB_SYNC_EDGE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cb_sync_filt
    import cb_sync_pkg::*;
#(
    parameter int               U_DLY     = 1,
    parameter int               WIDTH     = 8,
    parameter int               STAGES    = 2,
    parameter int               FILT_CNT  = 4,
    parameter logic [WIDTH-1:0] INT_VALUE = '0
) (
    input  wire logic             clk_sys,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] dat_in,
    output      logic [WIDTH-1:0] dat_out,
    output      logic [WIDTH-1:0] rise_pls,
    output      logic [WIDTH-1:0] fall_pls
);

    // U_DLY is kept for drop-in compatibility; registers update with zero delay.
    generate
        if (WIDTH < 1 || STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX
            || U_DLY < 0) begin : g_param_err
            $error("cb_sync_filt: illegal WIDTH/STAGES/U_DLY parameterisation");
        end
    endgenerate

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            cb_sync_filt_if #(.WIDTH(1)) u_ch_if ();

            assign u_ch_if.dat_in = dat_in[i];
            assign dat_out[i]     = u_ch_if.dat_out[0];
            assign rise_pls[i]    = u_ch_if.rise_pls[0];
            assign fall_pls[i]    = u_ch_if.fall_pls[0];

            cb_sync_filt_ch #(
                .STAGES   (STAGES),
                .FILT_CNT (FILT_CNT),
                .INT_BIT  (INT_VALUE[i])
            ) u_ch (
                .clk_sys (clk_sys),
                .rst     (rst),
                .bus     (u_ch_if.slave)
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cb_sync_filt.sv
// ============================================================================
// Module      : tb_cb_sync_filt
// Description : Directed bench for cb_sync_filt (filtered and bypass builds);
//               pulse expectations follow macro CB_SYNC_EDGE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cb_sync_filt;

`ifdef CB_SYNC_EDGE_EN
    localparam bit EDGE_ON = 1'b1;
`else
    localparam bit EDGE_ON = 1'b0;
`endif

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    cb_sync_filt_if #(.WIDTH(4)) bus   ();
    cb_sync_filt_if #(.WIDTH(4)) bus_b ();

    cb_sync_filt #(
        .U_DLY(1), .WIDTH(4), .STAGES(2), .FILT_CNT(4), .INT_VALUE(4'b1010)
    ) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .dat_in   (bus.dat_in),
        .dat_out  (bus.dat_out),
        .rise_pls (bus.rise_pls),
        .fall_pls (bus.fall_pls)
    );

    cb_sync_filt #(
        .U_DLY(1), .WIDTH(4), .STAGES(3), .FILT_CNT(0), .INT_VALUE(4'b0000)
    ) dut_byp (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .dat_in   (bus_b.dat_in),
        .dat_out  (bus_b.dat_out),
        .rise_pls (bus_b.rise_pls),
        .fall_pls (bus_b.fall_pls)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    function automatic logic [3:0] pm(input logic [3:0] v);
        return EDGE_ON ? v : 4'b0000;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.dat_in   = 4'b0101;
        bus_b.dat_in = 4'b0000;
        repeat (3) tick();
        checks++; if (bus.dat_out !== 4'b1010) begin errors++; $display("FAIL reset_out actual=%b expected=%b", bus.dat_out, 4'b1010); end
        checks++; if (bus.rise_pls !== 4'b0000) begin errors++; $display("FAIL reset_rise actual=%b expected=%b", bus.rise_pls, 4'b0000); end
        checks++; if (bus.fall_pls !== 4'b0000) begin errors++; $display("FAIL reset_fall actual=%b expected=%b", bus.fall_pls, 4'b0000); end
        checks++; if (bus_b.dat_out !== 4'b0000) begin errors++; $display("FAIL reset_byp_out actual=%b expected=%b", bus_b.dat_out, 4'b0000); end
        rst = 1'b0;
        bus.dat_in = 4'b1010;
        tick();
        checks++; if (bus.dat_out !== 4'b1010) begin errors++; $display("FAIL release_out actual=%b expected=%b", bus.dat_out, 4'b1010); end
        checks++; if ((bus.rise_pls | bus.fall_pls) !== 4'b0000) begin errors++; $display("FAIL release_pls actual=%b expected=%b", bus.rise_pls | bus.fall_pls, 4'b0000); end
    endtask

    // Channels 1 and 3 leave their reset value of 1.
    task automatic test_fall();
        bus.dat_in = 4'b0000;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++; if (bus.dat_out !== ((k >= 6) ? 4'b0000 : 4'b1010)) begin errors++; $display("FAIL fall_out k=%0d actual=%b expected=%b", k, bus.dat_out, (k >= 6) ? 4'b0000 : 4'b1010); end
            checks++; if (bus.fall_pls !== ((k == 6) ? pm(4'b1010) : 4'b0000)) begin errors++; $display("FAIL fall_pls k=%0d actual=%b expected=%b", k, bus.fall_pls, (k == 6) ? pm(4'b1010) : 4'b0000); end
            checks++; if (bus.rise_pls !== 4'b0000) begin errors++; $display("FAIL fall_rise k=%0d actual=%b expected=%b", k, bus.rise_pls, 4'b0000); end
        end
    endtask

    task automatic test_filtered();
        bus.dat_in = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++; if (bus.dat_out !== ((k >= 6) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL filt_out k=%0d actual=%b expected=%b", k, bus.dat_out, (k >= 6) ? 4'b0001 : 4'b0000); end
            checks++; if (bus.rise_pls !== ((k == 6) ? pm(4'b0001) : 4'b0000)) begin errors++; $display("FAIL filt_rise k=%0d actual=%b expected=%b", k, bus.rise_pls, (k == 6) ? pm(4'b0001) : 4'b0000); end
            checks++; if (bus.fall_pls !== 4'b0000) begin errors++; $display("FAIL filt_fall k=%0d actual=%b expected=%b", k, bus.fall_pls, 4'b0000); end
        end
    endtask

    task automatic test_glitch();
        bus.dat_in = 4'b0011;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) bus.dat_in = 4'b0001;
            checks++; if (bus.dat_out !== 4'b0001) begin errors++; $display("FAIL glitch_out k=%0d actual=%b expected=%b", k, bus.dat_out, 4'b0001); end
            checks++; if ((bus.rise_pls | bus.fall_pls) !== 4'b0000) begin errors++; $display("FAIL glitch_pls k=%0d actual=%b expected=%b", k, bus.rise_pls | bus.fall_pls, 4'b0000); end
        end
    endtask

    // Channel 2 sees 1,1,0 then 1 held; the count must restart after the 0.
    task automatic test_bounce();
        for (int k = 1; k <= 10; k++) begin
            bus.dat_in = (k == 3) ? 4'b0001 : 4'b0101;
            tick();
            checks++; if (bus.dat_out !== ((k >= 9) ? 4'b0101 : 4'b0001)) begin errors++; $display("FAIL bounce_out k=%0d actual=%b expected=%b", k, bus.dat_out, (k >= 9) ? 4'b0101 : 4'b0001); end
            checks++; if (bus.rise_pls !== ((k == 9) ? pm(4'b0100) : 4'b0000)) begin errors++; $display("FAIL bounce_rise k=%0d actual=%b expected=%b", k, bus.rise_pls, (k == 9) ? pm(4'b0100) : 4'b0000); end
        end
    endtask

    task automatic test_bypass();
        bus_b.dat_in = 4'b1111;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (bus_b.dat_out !== ((k >= 3) ? 4'b1111 : 4'b0000)) begin errors++; $display("FAIL byp_out k=%0d actual=%b expected=%b", k, bus_b.dat_out, (k >= 3) ? 4'b1111 : 4'b0000); end
            checks++; if (bus_b.rise_pls !== ((k == 3) ? pm(4'b1111) : 4'b0000)) begin errors++; $display("FAIL byp_rise k=%0d actual=%b expected=%b", k, bus_b.rise_pls, (k == 3) ? pm(4'b1111) : 4'b0000); end
            checks++; if (bus_b.fall_pls !== 4'b0000) begin errors++; $display("FAIL byp_fall k=%0d actual=%b expected=%b", k, bus_b.fall_pls, 4'b0000); end
        end
    endtask

    // Channel 0 starts falling; reset lands when its count has reached 2.
    task automatic test_mid_reset();
        bus.dat_in = 4'b0100;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (bus.dat_out !== 4'b0101) begin errors++; $display("FAIL midrst_pre k=%0d actual=%b expected=%b", k, bus.dat_out, 4'b0101); end
        end
        rst = 1'b1;
        tick();
        checks++; if (bus.dat_out !== 4'b1010) begin errors++; $display("FAIL midrst_out actual=%b expected=%b", bus.dat_out, 4'b1010); end
        checks++; if ((bus.rise_pls | bus.fall_pls) !== 4'b0000) begin errors++; $display("FAIL midrst_pls actual=%b expected=%b", bus.rise_pls | bus.fall_pls, 4'b0000); end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++; if (bus.dat_out !== ((k >= 6) ? 4'b0100 : 4'b1010)) begin errors++; $display("FAIL postrst_out k=%0d actual=%b expected=%b", k, bus.dat_out, (k >= 6) ? 4'b0100 : 4'b1010); end
            checks++; if (bus.rise_pls !== ((k == 6) ? pm(4'b0100) : 4'b0000)) begin errors++; $display("FAIL postrst_rise k=%0d actual=%b expected=%b", k, bus.rise_pls, (k == 6) ? pm(4'b0100) : 4'b0000); end
            checks++; if (bus.fall_pls !== ((k == 6) ? pm(4'b1010) : 4'b0000)) begin errors++; $display("FAIL postrst_fall k=%0d actual=%b expected=%b", k, bus.fall_pls, (k == 6) ? pm(4'b1010) : 4'b0000); end
        end
    endtask

    initial begin
        test_reset();
        test_fall();
        test_filtered();
        test_glitch();
        test_bounce();
        test_bypass();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
